// File: rtl/jvm_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port byte memory.
// One access at a time: IDLE -> ISSUE (start strobe) -> WAIT (handshake/timeout) -> DONE (done pulse).
module jvm_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     r0_req,
  input  logic [ADDRESS_WIDTH-1:0] r0_addr,
  input  logic                     r0_rwn,
  input  logic [7:0]               r0_wdata,
  output logic                     r0_done,
  output logic [7:0]               r0_rdata,
  input  logic                     r1_req,
  input  logic [ADDRESS_WIDTH-1:0] r1_addr,
  input  logic                     r1_rwn,
  input  logic [7:0]               r1_wdata,
  output logic                     r1_done,
  output logic [7:0]               r1_rdata,
  output logic                     mem_start,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_rwn,
  output logic [7:0]               mem_data_in,
  input  logic                     mem_ready,
  input  logic [7:0]               mem_data_out,
  output logic                     busy,
  output logic                     owner,
  output logic                     timeout_err,
  output logic [1:0]               dbg_state
);

  // Handshake: rN_req is a level held until rN_done; the memory is started by a
  // one-cycle mem_start and an access is complete once mem_ready has been seen low then high.

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t                     state, state_nxt;
  logic                       last_grant, last_grant_nxt;
  logic                       seen_busy, seen_busy_nxt;
  logic [CW-1:0]              wait_cnt, wait_cnt_nxt;
  logic                       win;
  logic                       mem_start_nxt, mem_rwn_nxt, busy_nxt, owner_nxt, timeout_err_nxt;
  logic [ADDRESS_WIDTH-1:0]   mem_address_nxt;
  logic [7:0]                 mem_data_in_nxt, r0_rdata_nxt, r1_rdata_nxt;
  logic                       r0_done_nxt, r1_done_nxt;

  assign dbg_state = state;

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    seen_busy_nxt   = seen_busy;
    wait_cnt_nxt    = wait_cnt;
    mem_start_nxt   = 1'b0;
    mem_address_nxt = mem_address;
    mem_rwn_nxt     = mem_rwn;
    mem_data_in_nxt = mem_data_in;
    owner_nxt       = owner;
    timeout_err_nxt = timeout_err;
    r0_done_nxt     = 1'b0;
    r1_done_nxt     = 1'b0;
    r0_rdata_nxt    = r0_rdata;
    r1_rdata_nxt    = r1_rdata;
    // Under contention the requester that did not win last time goes next.
    win = (r0_req && r1_req) ? ~last_grant : r1_req;

    case (state)
      IDLE: begin
        if (mem_ready && (r0_req || r1_req)) begin
          mem_address_nxt = win ? r1_addr   : r0_addr;
          mem_rwn_nxt     = win ? r1_rwn    : r0_rwn;
          mem_data_in_nxt = win ? r1_wdata  : r0_wdata;
          owner_nxt       = win;
          last_grant_nxt  = win;
          mem_start_nxt   = 1'b1;
          state_nxt       = ISSUE;
        end
      end
      ISSUE: begin
        seen_busy_nxt = 1'b0;
        wait_cnt_nxt  = '0;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (mem_ready && seen_busy) begin
          if (mem_rwn) begin
            if (owner) r1_rdata_nxt = mem_data_out;
            else       r0_rdata_nxt = mem_data_out;
          end
          r0_done_nxt = ~owner;
          r1_done_nxt = owner;
          state_nxt   = DONE;
        end else if (wait_cnt == CNT_LAST) begin
          timeout_err_nxt = 1'b1;
          r0_done_nxt     = ~owner;
          r1_done_nxt     = owner;
          state_nxt       = DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
          if (!mem_ready) seen_busy_nxt = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      seen_busy   <= 1'b0;
      wait_cnt    <= '0;
      mem_start   <= 1'b0;
      mem_address <= '0;
      mem_rwn     <= 1'b0;
      mem_data_in <= '0;
      busy        <= 1'b0;
      owner       <= 1'b0;
      timeout_err <= 1'b0;
      r0_done     <= 1'b0;
      r1_done     <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      seen_busy   <= seen_busy_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_start   <= mem_start_nxt;
      mem_address <= mem_address_nxt;
      mem_rwn     <= mem_rwn_nxt;
      mem_data_in <= mem_data_in_nxt;
      busy        <= busy_nxt;
      owner       <= owner_nxt;
      timeout_err <= timeout_err_nxt;
      r0_done     <= r0_done_nxt;
      r1_done     <= r1_done_nxt;
      r0_rdata    <= r0_rdata_nxt;
      r1_rdata    <= r1_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_jvm_mem_arbiter.sv
// Bench for jvm_mem_arbiter: directed table, multi-cycle corner sequences and a
// randomized run against a transaction-level shadow memory with a fairness rule.
module tb_jvm_mem_arbiter;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       r0_req = 1'b0, r0_rwn = 1'b1, r1_req = 1'b0, r1_rwn = 1'b1;
  logic [7:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
  logic       r0_done, r1_done, mem_start, mem_rwn, mem_ready, busy, owner, timeout_err;
  logic [7:0] r0_rdata, r1_rdata, mem_address, mem_data_in, mem_data_out;
  logic [1:0] dbg_state;

  logic       force_ready = 1'b0, ready_block = 1'b0, mem_load = 1'b1;
  int         n_cmp = 0, n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] mem_arr [256];
  logic [7:0] shadow  [256];

  always #5 clk = ~clk;

  jvm_mem_arbiter #(.ADDRESS_WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_rwn(r0_rwn), .r0_wdata(r0_wdata),
    .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_rwn(r1_rwn), .r1_wdata(r1_wdata),
    .r1_done(r1_done), .r1_rdata(r1_rdata),
    .mem_start(mem_start), .mem_address(mem_address), .mem_rwn(mem_rwn),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready), .mem_data_out(mem_data_out),
    .busy(busy), .owner(owner), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 16) return 8'h5A;
    return 8'(i) ^ 8'hA5;
  endfunction

  // Memory: acts on the start strobe, then drops ready for exactly one cycle.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
    end else if (mem_start) begin
      if (mem_rwn) mem_data_out <= mem_arr[mem_address];
      else         mem_arr[mem_address] <= mem_data_in;
    end
    mem_ready <= (mem_start && !force_ready) ? 1'b0 : !ready_block;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no end want end");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic rq, input logic rwn,
                         input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin r0_req = rq; r0_rwn = rwn; r0_addr = a; r0_wdata = d; end
    else        begin r1_req = rq; r1_rwn = rwn; r1_addr = a; r1_wdata = d; end
  endtask

  task automatic do_reset();
    r0_req = 1'b0; r1_req = 1'b0; reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  // Steps until any done appears or max cycles pass; cyc = cycles stepped.
  task automatic wait_any_done(input int max, output int cyc, output logic port);
    cyc = 0;
    do begin step(); cyc++; end while (!(r0_done || r1_done) && cyc < max);
    port = r1_done;
  endtask

  typedef struct {
    logic       r0, r1, rwn0, rwn1;
    logic [7:0] a0, a1, d0, d1;
    logic       exp_owner;
    logic [7:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic r1, input logic rwn0, input logic rwn1,
                              input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] d0,
                              input logic [7:0] d1, input logic eo, input logic [7:0] er);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.rwn0 = rwn0; v.rwn1 = rwn1; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.exp_owner = eo; v.exp_rdata = er;
    return v;
  endfunction

  initial begin
    vec_t       tbl[9];
    int         cyc, prev, ndone, n0, n1, ns, found;
    logic       port;
    logic [7:0] got;
    logic       pend[2], is_rd[2];
    logic [7:0] raddr[2], rwd[2], last_rd[2];
    int         gap[2], age[2], waits[2], rnd_done;

    // Read 0x10, write/read 0x22, then contention cases whose losers drop out unserved.
    tbl[0] = mk(1, 0, 1, 1, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h5A);
    tbl[1] = mk(0, 1, 1, 0, 8'h00, 8'h22, 8'h00, 8'hC3, 1, 8'h00);
    tbl[2] = mk(0, 1, 1, 1, 8'h00, 8'h22, 8'h00, 8'h00, 1, 8'hC3);
    tbl[3] = mk(1, 1, 1, 0, 8'h22, 8'h40, 8'h00, 8'h11, 0, 8'hC3);
    tbl[4] = mk(1, 1, 0, 1, 8'h33, 8'h40, 8'h77, 8'h00, 1, 8'hE5);
    tbl[5] = mk(1, 0, 1, 1, 8'h33, 8'h00, 8'h00, 8'h00, 0, 8'h96);
    tbl[6] = mk(1, 0, 0, 1, 8'h50, 8'h00, 8'hAB, 8'h00, 0, 8'h96);
    tbl[7] = mk(0, 1, 1, 1, 8'h00, 8'h50, 8'h00, 8'h00, 1, 8'hAB);
    tbl[8] = mk(1, 1, 1, 1, 8'h50, 8'h10, 8'h00, 8'h00, 0, 8'hAB);

    // Reset values
    step(); step(); step();
    mem_load = 1'b0;
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_start", mem_start, 0);
    check("rst_owner", owner, 0);
    check("rst_done", {r1_done, r0_done}, 0);
    check("rst_rdata", {r1_rdata, r0_rdata}, 0);
    check("rst_err", timeout_err, 0);
    check("rst_state", dbg_state, 0);
    step();

    // Table-driven transactions
    for (int i = 0; i < 9; i++) begin
      set_req(0, tbl[i].r0, tbl[i].rwn0, tbl[i].a0, tbl[i].d0);
      set_req(1, tbl[i].r1, tbl[i].rwn1, tbl[i].a1, tbl[i].d1);
      exp_q.push_back(tbl[i].exp_rdata);
      step();
      check("tbl_start", mem_start, 1);
      check("tbl_busy", busy, 1);
      wait_any_done(12, cyc, port);
      check("tbl_latency", cyc + 1, 4);
      check("tbl_done_port", port, tbl[i].exp_owner);
      check("tbl_owner", owner, tbl[i].exp_owner);
      got = port ? r1_rdata : r0_rdata;
      check("tbl_rdata", got, exp_q.pop_front());
      r0_req = 1'b0; r1_req = 1'b0;
      step();
      check("tbl_done_width", {r1_done, r0_done}, 0);
      check("tbl_idle_busy", busy, 0);
    end

    // Continuous contention from reset: owners 0,1,0,1, dones 5 cycles apart
    do_reset();
    set_req(0, 1, 1, 8'h10, 8'h00);
    set_req(1, 1, 1, 8'h22, 8'h00);
    exp_q.push_back(W'(0)); exp_q.push_back(W'(1));
    exp_q.push_back(W'(0)); exp_q.push_back(W'(1));
    prev = 0; ndone = 0;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (r0_done || r1_done) begin
        if (ndone < 4) begin
          check("rr_owner", W'(r1_done), exp_q.pop_front());
          if (ndone == 0) check("rr_first", c, 4);
          else            check("rr_spacing", c - prev, 5);
        end
        prev = c;
        ndone++;
      end
    end
    check("rr_count", ndone, 4);
    r0_req = 1'b0; r1_req = 1'b0;
    step(); step(); step(); step(); step();

    // Dropped requests: r0 drops after grant, r1 pulses only while r0 is served
    do_reset();
    set_req(0, 1, 1, 8'h10, 8'h00);
    step();
    check("drop_start", mem_start, 1);
    r0_req = 1'b0;
    set_req(1, 1, 1, 8'h22, 8'h00);
    step();
    r1_req = 1'b0;
    n0 = 0; n1 = 0; ns = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      n0 += int'(r0_done); n1 += int'(r1_done); ns += int'(mem_start);
    end
    check("drop_r0_done", n0, 1);
    check("drop_r1_done", n1, 0);
    check("drop_no_start", ns, 0);
    check("drop_rdata", r0_rdata, 8'h5A);

    // Memory not ready in IDLE: no grant until ready returns
    ready_block = 1'b1;
    step();
    set_req(0, 1, 1, 8'h50, 8'h00);
    ns = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      ns += int'(mem_start) + int'(busy);
    end
    check("nready_no_grant", ns, 0);
    ready_block = 1'b0;
    found = 0;
    for (int c = 0; c < 4 && found == 0; c++) begin
      step();
      if (mem_start) found = 1;
    end
    check("nready_grant", found, 1);
    wait_any_done(8, cyc, port);
    check("nready_done", {r1_done, r0_done}, 1);
    check("nready_rdata", r0_rdata, 8'hAB);
    r0_req = 1'b0;
    step();

    // Timeout: memory never drops ready, so WAIT runs its full 16 cycles
    do_reset();
    set_req(0, 1, 1, 8'h10, 8'h00);
    wait_any_done(8, cyc, port);
    check("to_pre_rdata", r0_rdata, 8'h5A);
    r0_req = 1'b0;
    step();
    force_ready = 1'b1;
    set_req(0, 1, 1, 8'h33, 8'h00);
    found = 0;
    for (int c = 1; c <= 30 && found == 0; c++) begin
      step();
      if (c == 17) check("to_err_early", timeout_err, 0);
      if (r0_done) found = c;
    end
    check("to_latency", found, 18);
    check("to_err", timeout_err, 1);
    check("to_rdata_kept", r0_rdata, 8'h5A);
    r0_req = 1'b0;
    step();
    force_ready = 1'b0;
    step();
    set_req(1, 1, 1, 8'h40, 8'h00);
    step();
    wait_any_done(12, cyc, port);
    check("to_next_latency", cyc + 1, 4);
    check("to_next_rdata", r1_rdata, 8'hE5);
    check("to_err_sticky", timeout_err, 1);
    r1_req = 1'b0;
    step();

    // Reset while in WAIT: everything clears, no done, next access normal
    set_req(0, 1, 1, 8'h10, 8'h00);
    step(); step();
    check("rmid_in_wait", dbg_state, 2);
    r0_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rmid_state", dbg_state, 0);
    check("rmid_busy", busy, 0);
    check("rmid_mem", {mem_start, mem_rwn, mem_address, mem_data_in}, 0);
    check("rmid_owner", owner, 0);
    check("rmid_rdata", {r1_rdata, r0_rdata}, 0);
    check("rmid_err", timeout_err, 0);
    n0 = int'(r0_done) + int'(r1_done);
    for (int c = 0; c < 6; c++) begin
      step();
      n0 += int'(r0_done) + int'(r1_done);
    end
    check("rmid_no_done", n0, 0);
    set_req(1, 1, 1, 8'h40, 8'h00);
    step();
    check("rmid_next_start", mem_start, 1);
    wait_any_done(12, cyc, port);
    check("rmid_next_latency", cyc + 1, 4);
    check("rmid_next_rdata", r1_rdata, 8'hE5);
    r1_req = 1'b0;
    step();

    // Randomized traffic against a shadow memory and a one-turn fairness bound
    mem_load = 1'b1;
    step();
    mem_load = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    do_reset();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; is_rd[p] = 0; raddr[p] = '0; rwd[p] = '0; last_rd[p] = '0;
      gap[p] = 0; age[p] = 0; waits[p] = 0;
    end
    rnd_done = 0;
    for (int c = 0; c < 800; c++) begin
      logic dn[2];
      step();
      dn[0] = r0_done; dn[1] = r1_done;
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) age[p]++;
        if (dn[p]) begin
          check("rnd_done_pending", pend[p], 1);
          got = (p == 1) ? r1_rdata : r0_rdata;
          if (is_rd[p]) check("rnd_read", got, shadow[raddr[p]]);
          else begin
            check("rnd_write_keeps", got, last_rd[p]);
            shadow[raddr[p]] = rwd[p];
          end
          check("rnd_age", age[p] <= 20, 1);
          last_rd[p] = got;
          pend[p] = 0; waits[p] = 0; age[p] = 0;
          gap[p] = $urandom_range(0, 3);
          set_req(p, 0, 1, 8'h00, 8'h00);
          rnd_done++;
          if (pend[1-p]) begin
            waits[1-p]++;
            check("rnd_fairness", waits[1-p] <= 1, 1);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && !dn[p]) begin
          if (gap[p] > 0) gap[p]--;
          else begin
            pend[p] = 1; age[p] = 0;
            is_rd[p] = 1'($urandom_range(0, 1));
            raddr[p] = 8'h60 + 8'($urandom_range(0, 7));
            rwd[p] = 8'($urandom_range(0, 255));
            set_req(p, 1, is_rd[p], raddr[p], rwd[p]);
          end
        end
      end
    end
    check("rnd_progress", rnd_done >= 100, 1);
    check("rnd_no_timeout", timeout_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
